// File: rtl/branch_update_queue_pkg.sv
// Shared entry layout for the branch update queue; the component-prediction bit
// order is common to the chooser and the predictor tables.
package branch_update_queue_pkg;

    localparam int PRED_GSHARE  = 0;
    localparam int PRED_BIMODAL = 1;
    localparam int PRED_LOCAL   = 2;
    localparam int PRED_CHOICE  = 3;
    localparam int ENTRY_PC_LSB = 4;
    localparam int ENTRY_META_W = 4;

    function automatic int entry_width(input int pc_width);
        return pc_width + ENTRY_META_W;
    endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Fetch push, execute resolve and predictor update signals of the branch queue.
interface branch_update_queue_if #(
    parameter int PC_WIDTH = 32
);
    logic                push_valid;
    logic                push_ready;
    logic [PC_WIDTH-1:0] push_pc;
    logic                push_gshare;
    logic                push_bimodal;
    logic                push_local;
    logic                push_choice;
    logic                resolve_valid;
    logic                resolve_taken;
    logic                upd_valid;
    logic                upd_outcome;
    logic [PC_WIDTH-1:0] upd_pc;
    logic                upd_gshare;
    logic                upd_bimodal;
    logic                upd_local;
    logic                upd_mispredict;

    modport master (
        output push_valid, push_pc, push_gshare, push_bimodal, push_local, push_choice,
        output resolve_valid, resolve_taken,
        input  push_ready,
        input  upd_valid, upd_outcome, upd_pc, upd_gshare, upd_bimodal, upd_local,
        input  upd_mispredict
    );

    modport slave (
        input  push_valid, push_pc, push_gshare, push_bimodal, push_local, push_choice,
        input  resolve_valid, resolve_taken,
        output push_ready,
        output upd_valid, upd_outcome, upd_pc, upd_gshare, upd_bimodal, upd_local,
        output upd_mispredict
    );

endinterface

// File: rtl/branch_update_queue_mem.sv
// Entry storage: synchronous write at tail, asynchronous read at head.
module branch_update_queue_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_update_queue.sv
// In-flight branch queue: pops the oldest branch on resolve, emits a registered
// update bundle and squashes all younger entries on a mispredict.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    branch_update_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   resolve_error_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(PC_WIDTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                err_q, err_d;
    logic                upd_valid_q, upd_valid_d, upd_mis_q, upd_mis_d;
    logic                upd_outcome_q, upd_outcome_d;
    logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic                upd_gshare_q, upd_gshare_d;
    logic                upd_bimodal_q, upd_bimodal_d;
    logic                upd_local_q, upd_local_d;

    logic [ENTRY_W-1:0]  wdata, head_entry;
    logic                do_push, do_resolve, mispredict, wr_en;

    branch_update_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (tail_q),
        .wdata_i (wdata),
        .raddr_i (head_q),
        .rdata_o (head_entry)
    );

    assign empty_o         = (count_q == '0);
    assign full_o          = (count_q == DEPTH_C);
    assign count_o         = count_q;
    assign resolve_error_o = err_q;
    assign bus.push_ready  = !full_o;

    always_comb begin
        wdata                                = '0;
        wdata[PRED_GSHARE]                   = bus.push_gshare;
        wdata[PRED_BIMODAL]                  = bus.push_bimodal;
        wdata[PRED_LOCAL]                    = bus.push_local;
        wdata[PRED_CHOICE]                   = bus.push_choice;
        wdata[ENTRY_PC_LSB +: PC_WIDTH]      = bus.push_pc;
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        err_d         = err_q;
        upd_valid_d   = 1'b0;
        upd_mis_d     = 1'b0;
        upd_outcome_d = upd_outcome_q;
        upd_pc_d      = upd_pc_q;
        upd_gshare_d  = upd_gshare_q;
        upd_bimodal_d = upd_bimodal_q;
        upd_local_d   = upd_local_q;
        wr_en         = 1'b0;
        do_push       = bus.push_valid && !full_o;
        do_resolve    = bus.resolve_valid && !empty_o;
        mispredict    = head_entry[PRED_CHOICE] != bus.resolve_taken;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (bus.resolve_valid && empty_o) begin
                err_d = 1'b1;
            end
            if (do_resolve) begin
                upd_valid_d   = 1'b1;
                upd_mis_d     = mispredict;
                upd_outcome_d = bus.resolve_taken;
                upd_pc_d      = head_entry[ENTRY_PC_LSB +: PC_WIDTH];
                upd_gshare_d  = head_entry[PRED_GSHARE];
                upd_bimodal_d = head_entry[PRED_BIMODAL];
                upd_local_d   = head_entry[PRED_LOCAL];
            end
            // A mispredict squashes everything younger, including a same-cycle push.
            if (do_resolve && mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                wr_en   = do_push;
                head_d  = head_q + PTR_W'(do_resolve);
                tail_d  = tail_q + PTR_W'(do_push);
                count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_resolve);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_mis_q     <= 1'b0;
            upd_outcome_q <= 1'b0;
            upd_pc_q      <= '0;
            upd_gshare_q  <= 1'b0;
            upd_bimodal_q <= 1'b0;
            upd_local_q   <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            err_q         <= err_d;
            upd_valid_q   <= upd_valid_d;
            upd_mis_q     <= upd_mis_d;
            upd_outcome_q <= upd_outcome_d;
            upd_pc_q      <= upd_pc_d;
            upd_gshare_q  <= upd_gshare_d;
            upd_bimodal_q <= upd_bimodal_d;
            upd_local_q   <= upd_local_d;
        end
    end

    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_mispredict = upd_mis_q;
    assign bus.upd_outcome    = upd_outcome_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_gshare     = upd_gshare_q;
    assign bus.upd_bimodal    = upd_bimodal_q;
    assign bus.upd_local      = upd_local_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed plus random checks of branch_update_queue against a queue-based model.
module tb_branch_update_queue;

    localparam int DEPTH = 8;
    localparam int PCW   = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        g;
        logic        b;
        logic        l;
        logic        c;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] count;
    logic       empty, full, rerr;

    branch_update_queue_if #(.PC_WIDTH(PCW)) bus ();

    branch_update_queue #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PCW)
    ) dut (
        .clk             (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .bus             (bus),
        .count_o         (count),
        .empty_o         (empty),
        .full_o          (full),
        .resolve_error_o (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t q[$];
    bit   err_m;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the queue rules, then compare.
    task automatic step(input bit rn, input bit pv, input logic [31:0] pc,
                        input bit g, input bit b, input bit l, input bit c,
                        input bit rv, input bit rt, input bit fl);
        ent_t e;
        ent_t ue;
        bit   acc;
        bit   uv;
        bit   mis;
        rst_n             = rn;
        bus.push_valid    = pv;
        bus.push_pc       = pc;
        bus.push_gshare   = g;
        bus.push_bimodal  = b;
        bus.push_local    = l;
        bus.push_choice   = c;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        flush             = fl;
        uv  = 0;
        mis = 0;
        ue  = '0;
        if (!rn) begin
            q.delete();
            err_m = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            acc = pv && (q.size() < DEPTH);
            if (rv && q.size() == 0) begin
                err_m = 1;
            end else if (rv) begin
                ue  = q.pop_front();
                uv  = 1;
                mis = (ue.c != rt);
                if (mis) begin
                    q.delete();
                    acc = 0;
                end
            end
            if (acc) begin
                e.pc = pc; e.g = g; e.b = b; e.l = l; e.c = c;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("push_ready", 32'(bus.push_ready), 32'(q.size() != DEPTH));
        chk("resolve_error", 32'(rerr), 32'(err_m));
        chk("upd_valid", 32'(bus.upd_valid), 32'(uv));
        if (!rn) begin
            chk("rst_upd_mispredict", 32'(bus.upd_mispredict), 32'd0);
            chk("rst_upd_pc", bus.upd_pc, 32'd0);
            chk("rst_upd_outcome", 32'(bus.upd_outcome), 32'd0);
            chk("rst_upd_preds", {29'd0, bus.upd_gshare, bus.upd_bimodal, bus.upd_local}, 32'd0);
        end
        if (uv) begin
            chk("upd_pc", bus.upd_pc, ue.pc);
            chk("upd_outcome", 32'(bus.upd_outcome), 32'(rt));
            chk("upd_gshare", 32'(bus.upd_gshare), 32'(ue.g));
            chk("upd_bimodal", 32'(bus.upd_bimodal), 32'(ue.b));
            chk("upd_local", 32'(bus.upd_local), 32'(ue.l));
            chk("upd_mispredict", 32'(bus.upd_mispredict), 32'(mis));
        end
    endtask

    task automatic push(input logic [31:0] pc, input bit g, input bit b, input bit l, input bit c);
        step(1, 1, pc, g, b, l, c, 0, 0, 0);
    endtask

    task automatic resolve(input bit rt);
        step(1, 0, 32'h0, 0, 0, 0, 0, 1, rt, 0);
    endtask

    task automatic idle();
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          c, rt, pv, rv, fl, rn;
        logic [31:0] pc;
        rst_n = 0; flush = 0;
        bus.push_valid = 0; bus.push_pc = '0; bus.push_gshare = 0; bus.push_bimodal = 0;
        bus.push_local = 0; bus.push_choice = 0; bus.resolve_valid = 0; bus.resolve_taken = 0;

        step(0, 1, 32'hdead, 1, 1, 1, 1, 1, 1, 0);
        step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

        // three taken branches drain in order
        push(32'h100, 0, 0, 0, 1);
        push(32'h104, 0, 0, 0, 1);
        push(32'h108, 0, 0, 0, 1);
        resolve(1); resolve(1); resolve(1);
        idle();

        // fill with push held, ninth push refused, resolve frees one slot
        for (int i = 0; i < 9; i++) push(32'h200 + 32'(4 * i), 0, 1, 0, 1);
        step(1, 1, 32'h300, 0, 0, 0, 1, 1, 1, 0);
        push(32'h300, 0, 0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1);

        // mispredict at head squashes queue and same-cycle push
        push(32'h400, 1, 1, 0, 1);
        push(32'h404, 0, 0, 0, 0);
        push(32'h408, 0, 0, 0, 1);
        push(32'h40c, 0, 0, 0, 1);
        step(1, 1, 32'h410, 0, 0, 0, 1, 1, 0, 0);
        idle();

        // component predictions carried into the update
        push(32'h500, 1, 0, 1, 0);
        resolve(0);

        // resolve on empty sets sticky error; flush beats resolve
        resolve(1);
        idle();
        for (int i = 0; i < 5; i++) push(32'h600 + 32'(4 * i), 0, 0, 0, 1);
        step(1, 1, 32'h700, 0, 0, 0, 1, 1, 1, 1);
        idle();

        // pointer wrap with paired push/resolve, then reset mid-stream
        push(32'h800, 0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 1, 32'h800 + 32'(4 * i), i[0], 0, 0, 1, 1, 1, 0);
        push(32'h900, 0, 0, 0, 1);
        step(1, 1, 32'h904, 0, 0, 0, 1, 1, 1, 0);
        step(0, 1, 32'h908, 0, 0, 0, 1, 1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            pv = ($urandom % 4) != 0;
            rv = ($urandom % 3) == 0;
            c  = $urandom % 2;
            pc = $urandom & 32'hffff_fffc;
            if (q.size() != 0 && ($urandom % 8) != 0) rt = q[0].c;
            else rt = $urandom % 2;
            fl = ($urandom % 40) == 0;
            rn = ($urandom % 100) != 0;
            step(rn, pv, pc, $urandom % 2, $urandom % 2, $urandom % 2, c, rv, rt, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
